// File: rtl/mfda_valve_pkg.sv
// Shared types and helpers for the 8:1 valve-tree mux sequencer.
//   seq_state_e      : sequencer FSM states
//   VALVE_ALL_CLOSED : every control line pressurised (all valves closed)
//   mux8_pattern()   : per-level valve pattern that routes input index sel
package mfda_valve_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STAGE = 2'd1,
    OPEN  = 2'd2,
    CLOSE = 2'd3
  } seq_state_e;

  localparam logic [5:0] VALVE_ALL_CLOSED = 6'b111111;

  // Bit order [0]=c1 .. [5]=c6, 1 = closed. Each level opens exactly one of its
  // two valves, chosen by the matching select bit.
  function automatic logic [5:0] mux8_pattern(input logic [2:0] sel);
    return {~sel[2], sel[2], ~sel[1], sel[1], ~sel[0], sel[0]};
  endfunction

endpackage

// File: rtl/valve_hold_timer.sv
// Hold timer shared by every sequencer state.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_load         : load i_load_val (hold length minus one)
//   i_load_val     : value loaded on state entry
//   o_zero         : counter has reached zero (last cycle of the hold)
module valve_hold_timer #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Saturates at zero so an unattended counter never wraps.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)               r_cnt <= '0;
    else if (i_load)            r_cnt <= i_load_val;
    else if (r_cnt != '0)       r_cnt <= r_cnt - CNT_W'(1);
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mux8_valve_sequencer.sv
// Sequencer for the six pneumatic control lines of an 8:1 valve-tree mux.
// One request at a time: stage levels 1-2, settle, open the output level for
// the dwell, close everything, settle, then pulse done (or aborted).
//   clk, rst_n            : clock, synchronous active-low reset
//   req_valid/req_ready   : request handshake (ready only while idle)
//   req_sel, req_dwell    : input index 0..7 and open time in cycles (0 -> 1)
//   abort                 : abandon the route during STAGE/OPEN
//   valve_ctrl[5:0]       : c6..c1, 1 = pressurised = closed (registered)
//   flow_open             : output level open
//   busy                  : not idle
//   done / aborted        : one-cycle completion pulses
module mux8_valve_sequencer
  import mfda_valve_pkg::*;
#(
  parameter int SETTLE_CYC = 8,
  parameter int DWELL_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_sel,
  input  logic [DWELL_W-1:0] req_dwell,
  input  logic               abort,
  output logic [5:0]         valve_ctrl,
  output logic               flow_open,
  output logic               busy,
  output logic               done,
  output logic               aborted
);

  localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);
  localparam int CNT_W    = (DWELL_W > SETTLE_W) ? DWELL_W : SETTLE_W;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [5:0] OUT_LEVEL_CLOSED  = 6'b110000;

  seq_state_e         r_state, w_nxt_state;
  logic [2:0]         r_sel;
  logic [DWELL_W-1:0] r_dwell;
  logic               r_aborting, w_nxt_aborting;
  logic [5:0]         r_valve, w_nxt_valve;
  logic               r_flow, w_nxt_flow;
  logic               r_done, w_nxt_done;
  logic               r_aborted, w_nxt_aborted;
  logic               w_load;
  logic [CNT_W-1:0]   w_load_val;
  logic [CNT_W-1:0]   w_dwell_load;
  logic [DWELL_W-1:0] w_dwell_m1;
  logic               w_zero;
  logic               w_accept;

  // Ready is withheld during the completion pulse so the next request lands
  // no earlier than the cycle after done/aborted.
  assign req_ready = (r_state == IDLE) && !r_done && !r_aborted;
  assign w_accept  = req_valid && req_ready;
  assign busy      = (r_state != IDLE);

  // A zero dwell still opens the output level for one cycle.
  assign w_dwell_m1   = r_dwell - DWELL_W'(1);
  assign w_dwell_load = (r_dwell == '0) ? '0 : CNT_W'(w_dwell_m1);

  valve_hold_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_aborting = r_aborting;
    w_nxt_valve    = r_valve;
    w_nxt_flow     = r_flow;
    w_nxt_done     = 1'b0;
    w_nxt_aborted  = 1'b0;
    w_load         = 1'b0;
    w_load_val     = SETTLE_LOAD;
    case (r_state)
      IDLE: begin
        w_nxt_valve = VALVE_ALL_CLOSED;
        w_nxt_flow  = 1'b0;
        if (w_accept) begin
          w_nxt_state    = STAGE;
          w_nxt_aborting = 1'b0;
          w_nxt_valve    = mux8_pattern(req_sel) | OUT_LEVEL_CLOSED;
          w_load         = 1'b1;
        end
      end
      STAGE: begin
        if (abort) begin
          w_nxt_state    = CLOSE;
          w_nxt_aborting = 1'b1;
          w_nxt_valve    = VALVE_ALL_CLOSED;
          w_load         = 1'b1;
        end else if (w_zero) begin
          w_nxt_state = OPEN;
          w_nxt_valve = mux8_pattern(r_sel);
          w_nxt_flow  = 1'b1;
          w_load      = 1'b1;
          w_load_val  = w_dwell_load;
        end
      end
      OPEN: begin
        if (abort || w_zero) begin
          w_nxt_state    = CLOSE;
          w_nxt_aborting = abort;
          w_nxt_valve    = VALVE_ALL_CLOSED;
          w_nxt_flow     = 1'b0;
          w_load         = 1'b1;
        end
      end
      CLOSE: begin
        w_nxt_valve = VALVE_ALL_CLOSED;
        if (w_zero) begin
          w_nxt_state   = IDLE;
          w_nxt_done    = !r_aborting;
          w_nxt_aborted = r_aborting;
          w_load        = 1'b1;
          w_load_val    = '0;
        end
      end
      default: begin
        w_nxt_state = IDLE;
        w_nxt_valve = VALVE_ALL_CLOSED;
        w_nxt_flow  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_aborting <= 1'b0;
      r_valve    <= VALVE_ALL_CLOSED;
      r_flow     <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_aborting <= w_nxt_aborting;
      r_valve    <= w_nxt_valve;
      r_flow     <= w_nxt_flow;
      r_done     <= w_nxt_done;
      r_aborted  <= w_nxt_aborted;
    end
  end

  // Route parameters: captured on accept only, no reset needed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_sel   <= req_sel;
      r_dwell <= req_dwell;
    end
  end

  // Each level must keep at least one of its two valves closed.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (r_valve[0] | r_valve[1]);
      assert (r_valve[2] | r_valve[3]);
      assert (r_valve[4] | r_valve[5]);
    end
  end

  assign valve_ctrl = r_valve;
  assign flow_open  = r_flow;
  assign done       = r_done;
  assign aborted    = r_aborted;

endmodule

// File: tb/tb_mux8_valve_sequencer.sv
module tb_mux8_valve_sequencer;

  localparam int S  = 8;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst_n, req_valid, req_ready, abort;
  logic [2:0]    req_sel;
  logic [DW-1:0] req_dwell;
  logic [5:0]    valve_ctrl;
  logic          flow_open, busy, done, aborted;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mux8_valve_sequencer #(.SETTLE_CYC(S), .DWELL_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_sel    (req_sel),
    .req_dwell  (req_dwell),
    .abort      (abort),
    .valve_ctrl (valve_ctrl),
    .flow_open  (flow_open),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Behavioural model: a route is a timeline relative to its accept cycle.
  // k=1..S stage, then d cycles open, then closed until the end cycle E,
  // where the completion pulse shows. Abort at k moves E to k+S+1.
  bit         m_in = 1'b0;
  int         m_k, m_E, m_d;
  bit         m_ab;
  logic [2:0] m_sel;

  always @(posedge clk) begin
    if (!rst_n) m_in = 1'b0;
    else if (m_in) begin
      if (m_k == m_E) m_in = 1'b0;
      else begin
        if (abort && !m_ab && m_k <= S + m_d) begin
          m_ab = 1'b1;
          m_E  = m_k + S + 1;
        end
        m_k++;
      end
    end else if (req_valid) begin
      m_in  = 1'b1;
      m_k   = 1;
      m_sel = req_sel;
      m_d   = (req_dwell == '0) ? 1 : int'(req_dwell);
      m_E   = 2 * S + m_d + 1;
      m_ab  = 1'b0;
    end
  end

  // {valve_ctrl, flow_open, busy, req_ready, done, aborted}
  function automatic logic [10:0] model_out();
    logic [5:0] v;
    logic fl, bz, rd, dn, ab;
    v = 6'h3F; fl = 0; bz = 0; rd = 1; dn = 0; ab = 0;
    if (m_in) begin
      rd = 0;
      if (m_k == m_E) begin
        dn = !m_ab;
        ab = m_ab;
      end else begin
        bz = 1;
        if (m_k < m_E - S) begin
          // level L opens valve index 2L + sel[L]
          v[0 + int'(m_sel[0])] = 1'b0;
          v[2 + int'(m_sel[1])] = 1'b0;
          if (m_k > S) begin
            v[4 + int'(m_sel[2])] = 1'b0;
            fl = 1;
          end
        end
      end
    end
    return {v, fl, bz, rd, dn, ab};
  endfunction

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("outputs_vs_model", {valve_ctrl, flow_open, busy, req_ready, done, aborted}, model_out());
      chk("one_valve_per_level",
          (valve_ctrl[0] | valve_ctrl[1]) & (valve_ctrl[2] | valve_ctrl[3]) & (valve_ctrl[4] | valve_ctrl[5]), 1);
    end
  end

  // Called at a negedge while idle; returns at the negedge of cycle k=1.
  task automatic launch(input logic [2:0] s, input int d);
    req_valid = 1'b1;
    req_sel   = s;
    req_dwell = DW'(d);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("accepted", busy, 1);
  endtask

  // Steps from cycle k0 until a completion pulse or the limit.
  task automatic wait_end(input int k0, input int limit, output int k_end, output int flows,
                          output bit was_abort, output logic [5:0] open_ctrl);
    k_end = -1; flows = 0; was_abort = 0; open_ctrl = 6'h3F;
    for (int k = k0; k <= limit; k++) begin
      if (flow_open) begin
        flows++;
        open_ctrl = valve_ctrl;
      end
      if (done || aborted) begin
        k_end     = k;
        was_abort = aborted;
        break;
      end
      @(negedge clk);
    end
  endtask

  logic [5:0] open_tab [8] = '{6'h2A, 6'h29, 6'h26, 6'h25, 6'h1A, 6'h19, 6'h16, 6'h15};

  initial begin
    int kend, flows;
    bit wa;
    logic [5:0] oc;
    rst_n = 0; req_valid = 0; req_sel = 0; req_dwell = 0; abort = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_ctrl", valve_ctrl, 6'h3F);
    chk("reset_ready", req_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_pulses", {done, aborted}, 0);
    rst_n = 1;
    @(negedge clk);

    // sel=5, dwell=4
    launch(3'd5, 4);
    for (int k = 1; k <= 22; k++) begin
      if (k == 1)  chk("s5_stage", {valve_ctrl, flow_open}, {6'b111001, 1'b0});
      if (k == 8)  chk("s5_stage_end", valve_ctrl, 6'b111001);
      if (k == 9)  chk("s5_open", {valve_ctrl, flow_open}, {6'b011001, 1'b1});
      if (k == 12) chk("s5_open_end", {valve_ctrl, flow_open}, {6'b011001, 1'b1});
      if (k == 13) chk("s5_close", {valve_ctrl, flow_open}, {6'h3F, 1'b0});
      if (k == 20) chk("s5_close_end", {busy, done}, 2'b10);
      if (k == 21) chk("s5_done", {busy, done, aborted, req_ready}, 4'b0100);
      if (k == 22) chk("s5_ready", {done, req_ready}, 2'b01);
      @(negedge clk);
    end

    // every path with dwell=0
    for (int s = 0; s < 8; s++) begin
      launch(3'(s), 0);
      wait_end(1, 100, kend, flows, wa, oc);
      chk("dw0_latency", kend, 18);
      chk("dw0_flow_cycles", flows, 1);
      chk("dw0_pattern", oc, open_tab[s]);
      @(negedge clk);
    end

    // abort during OPEN (sel=2, dwell=100)
    launch(3'd2, 100);
    for (int k = 1; k < 11; k++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_closed", {valve_ctrl, flow_open, busy}, {6'h3F, 1'b0, 1'b1});
    wait_end(12, 60, kend, flows, wa, oc);
    chk("abort_end_cycle", kend, 20);
    chk("abort_pulse", wa, 1);
    chk("abort_no_done", done, 0);
    @(negedge clk);

    // abort together with a request while idle: request wins
    abort = 1'b1;
    launch(3'd3, 2);
    abort = 1'b0;
    wait_end(1, 60, kend, flows, wa, oc);
    chk("idle_abort_ignored", {kend[7:0], 7'(flows), wa}, {8'd19, 7'd2, 1'b0});
    @(negedge clk);

    // back-to-back with req_valid held high
    req_valid = 1; req_sel = 3'd1; req_dwell = DW'(3);
    @(posedge clk); @(negedge clk);
    wait_end(1, 60, kend, flows, wa, oc);
    chk("b2b_first", kend, 20);
    chk("b2b_ready_in_done", req_ready, 0);
    req_sel = 3'd6; req_dwell = DW'(2);
    @(negedge clk);
    chk("b2b_gap", {busy, req_ready}, 2'b01);
    @(negedge clk);
    chk("b2b_second_accept", {busy, req_ready}, 2'b10);
    req_valid = 0;
    wait_end(1, 60, kend, flows, wa, oc);
    chk("b2b_second", kend, 19);
    chk("b2b_second_pattern", oc, open_tab[6]);
    @(negedge clk);

    // reset mid-OPEN
    launch(3'd6, 50);
    for (int k = 1; k < 20; k++) @(negedge clk);
    chk("pre_reset_open", flow_open, 1);
    rst_n = 0;
    @(negedge clk);
    chk("mid_reset", {valve_ctrl, busy, done, aborted, req_ready}, {6'h3F, 4'b0001});
    rst_n = 1;
    @(negedge clk);
    launch(3'd7, 5);
    wait_end(1, 60, kend, flows, wa, oc);
    chk("after_reset_route", {kend[7:0], 7'(flows), wa}, {8'd22, 7'd5, 1'b0});
    @(negedge clk);

    // maximum dwell
    launch(3'd4, (1 << DW) - 1);
    wait_end(1, 1200, kend, flows, wa, oc);
    chk("max_dwell_end", kend, 1040);
    chk("max_dwell_flows", flows, 1023);
    @(negedge clk);

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      req_valid = ($urandom_range(0, 3) == 0);
      req_sel   = 3'($urandom_range(0, 7));
      req_dwell = DW'($urandom_range(0, 12));
      abort     = ($urandom_range(0, 29) == 0);
      rst_n     = ($urandom_range(0, 799) != 0);
      @(negedge clk);
    end
    req_valid = 0; abort = 0; rst_n = 1;
    repeat (60) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
